// File: rtl/alu_rs.sv
// Reservation station feeding the integer ALU: buffers micro-ops until both operands
// are valid, snoops two CDB ports, dispatches one ready entry per cycle.
// Optional macro RS_OLDEST_FIRST_EN: age-based (oldest-first) selection instead of lowest index.
module alu_rs #(
    parameter int unsigned RS_SIZE = 8,
    parameter int unsigned RS_BIT  = 3,
    parameter int unsigned ROB_BIT = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               flush,
    input  logic               issue_valid,
    input  logic [2:0]         issue_op,
    input  logic [6:0]         issue_op_type,
    input  logic               issue_op_addition,
    input  logic [ROB_BIT-1:0] issue_rob_entry,
    input  logic [31:0]        issue_vi,
    input  logic [31:0]        issue_vj,
    input  logic               issue_qi_valid,
    input  logic               issue_qj_valid,
    input  logic [ROB_BIT-1:0] issue_qi,
    input  logic [ROB_BIT-1:0] issue_qj,
    input  logic               cdb_alu_valid,
    input  logic [ROB_BIT-1:0] cdb_alu_rob,
    input  logic [31:0]        cdb_alu_val,
    input  logic               cdb_lsb_valid,
    input  logic [ROB_BIT-1:0] cdb_lsb_rob,
    input  logic [31:0]        cdb_lsb_val,
    output logic               full,
    output logic               alu_valid,
    output logic [31:0]        alu_vi,
    output logic [31:0]        alu_vj,
    output logic [2:0]         alu_op,
    output logic [6:0]         alu_op_type,
    output logic               alu_op_addition,
    output logic [ROB_BIT-1:0] alu_rob_entry
);

    localparam int unsigned VAL_W = 32;

    typedef struct packed {
        logic [2:0]         op;
        logic [6:0]         op_type;
        logic               op_addition;
        logic [ROB_BIT-1:0] rob;
        logic [VAL_W-1:0]   vi;
        logic [VAL_W-1:0]   vj;
        logic               qi_valid;
        logic [ROB_BIT-1:0] qi;
        logic               qj_valid;
        logic [ROB_BIT-1:0] qj;
`ifdef RS_OLDEST_FIRST_EN
        logic [RS_BIT-1:0]  age;
`endif
    } entry_t;

    entry_t             ent [RS_SIZE];
    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] ready;
    entry_t             new_ent;
    logic [RS_BIT-1:0]  free_idx;
    logic [RS_BIT-1:0]  sel_idx;
    logic               sel_found;
    logic               issue_take;

    assign full       = &busy;
    assign issue_take = issue_valid && !full;

    // Incoming micro-op, with same-cycle CDB capture of pending operands (ALU port wins)
    always_comb begin
        new_ent             = '0;
        new_ent.op          = issue_op;
        new_ent.op_type     = issue_op_type;
        new_ent.op_addition = issue_op_addition;
        new_ent.rob         = issue_rob_entry;
        new_ent.vi          = issue_vi;
        new_ent.vj          = issue_vj;
        new_ent.qi_valid    = issue_qi_valid;
        new_ent.qi          = issue_qi;
        new_ent.qj_valid    = issue_qj_valid;
        new_ent.qj          = issue_qj;
        if (issue_qi_valid) begin
            if (cdb_alu_valid && cdb_alu_rob == issue_qi) begin
                new_ent.vi       = cdb_alu_val;
                new_ent.qi_valid = 1'b0;
            end else if (cdb_lsb_valid && cdb_lsb_rob == issue_qi) begin
                new_ent.vi       = cdb_lsb_val;
                new_ent.qi_valid = 1'b0;
            end
        end
        if (issue_qj_valid) begin
            if (cdb_alu_valid && cdb_alu_rob == issue_qj) begin
                new_ent.vj       = cdb_alu_val;
                new_ent.qj_valid = 1'b0;
            end else if (cdb_lsb_valid && cdb_lsb_rob == issue_qj) begin
                new_ent.vj       = cdb_lsb_val;
                new_ent.qj_valid = 1'b0;
            end
        end
    end

    // Lowest free slot and ready vector, both from registered state
    always_comb begin
        free_idx = '0;
        ready    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = RS_BIT'(i);
            ready[i] = busy[i] && !ent[i].qi_valid && !ent[i].qj_valid;
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    logic [RS_BIT-1:0] best_age;

    // Greatest age wins; strict compare keeps ties on the lowest index
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready[i] && (!sel_found || ent[i].age > best_age)) begin
                sel_found = 1'b1;
                sel_idx   = RS_BIT'(i);
                best_age  = ent[i].age;
            end
        end
    end
`else
    always_comb begin
        sel_found = |ready;
        sel_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) sel_idx = RS_BIT'(i);
        end
    end
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy            <= '0;
            alu_valid       <= 1'b0;
            alu_vi          <= '0;
            alu_vj          <= '0;
            alu_op          <= '0;
            alu_op_type     <= '0;
            alu_op_addition <= 1'b0;
            alu_rob_entry   <= '0;
            for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                busy      <= '0;
                alu_valid <= 1'b0;
            end else begin
                // CDB wakeup of pending operands in busy entries
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i]) begin
                        if (ent[i].qi_valid && cdb_alu_valid && ent[i].qi == cdb_alu_rob) begin
                            ent[i].vi       <= cdb_alu_val;
                            ent[i].qi_valid <= 1'b0;
                        end else if (ent[i].qi_valid && cdb_lsb_valid && ent[i].qi == cdb_lsb_rob) begin
                            ent[i].vi       <= cdb_lsb_val;
                            ent[i].qi_valid <= 1'b0;
                        end
                        if (ent[i].qj_valid && cdb_alu_valid && ent[i].qj == cdb_alu_rob) begin
                            ent[i].vj       <= cdb_alu_val;
                            ent[i].qj_valid <= 1'b0;
                        end else if (ent[i].qj_valid && cdb_lsb_valid && ent[i].qj == cdb_lsb_rob) begin
                            ent[i].vj       <= cdb_lsb_val;
                            ent[i].qj_valid <= 1'b0;
                        end
`ifdef RS_OLDEST_FIRST_EN
                        if (issue_take && ent[i].age != RS_BIT'(RS_SIZE - 1))
                            ent[i].age <= ent[i].age + RS_BIT'(1);
`endif
                    end
                end

                if (sel_found) begin
                    alu_valid       <= 1'b1;
                    alu_vi          <= ent[sel_idx].vi;
                    alu_vj          <= ent[sel_idx].vj;
                    alu_op          <= ent[sel_idx].op;
                    alu_op_type     <= ent[sel_idx].op_type;
                    alu_op_addition <= ent[sel_idx].op_addition;
                    alu_rob_entry   <= ent[sel_idx].rob;
                    busy[sel_idx]   <= 1'b0;
                end else begin
                    alu_valid <= 1'b0;
                end

                // Free slot is never the dispatched slot, so both writes coexist
                if (issue_take) begin
                    ent[free_idx]  <= new_ent;
                    busy[free_idx] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: directed issue/CDB vectors push expected dispatches,
// a negedge monitor pops and compares each fresh ALU dispatch.
module tb_alu_rs;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    typedef struct packed {
        logic [31:0] vi;
        logic [31:0] vj;
        logic [2:0]  op;
        logic [6:0]  op_type;
        logic        op_addition;
        logic [3:0]  rob;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush;
    logic        issue_valid;
    logic [2:0]  issue_op;
    logic [6:0]  issue_op_type;
    logic        issue_op_addition;
    logic [3:0]  issue_rob_entry;
    logic [31:0] issue_vi, issue_vj;
    logic        issue_qi_valid, issue_qj_valid;
    logic [3:0]  issue_qi, issue_qj;
    logic        cdb_alu_valid, cdb_lsb_valid;
    logic [3:0]  cdb_alu_rob, cdb_lsb_rob;
    logic [31:0] cdb_alu_val, cdb_lsb_val;
    logic        full, alu_valid, alu_op_addition;
    logic [31:0] alu_vi, alu_vj;
    logic [2:0]  alu_op;
    logic [6:0]  alu_op_type;
    logic [3:0]  alu_rob_entry;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    logic rdy_edge = 1'b0;

    always #5 clk_in = ~clk_in;

    alu_rs dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_op_type(issue_op_type),
        .issue_op_addition(issue_op_addition), .issue_rob_entry(issue_rob_entry),
        .issue_vi(issue_vi), .issue_vj(issue_vj),
        .issue_qi_valid(issue_qi_valid), .issue_qj_valid(issue_qj_valid),
        .issue_qi(issue_qi), .issue_qj(issue_qj),
        .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob(cdb_alu_rob), .cdb_alu_val(cdb_alu_val),
        .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob(cdb_lsb_rob), .cdb_lsb_val(cdb_lsb_val),
        .full(full), .alu_valid(alu_valid), .alu_vi(alu_vi), .alu_vj(alu_vj),
        .alu_op(alu_op), .alu_op_type(alu_op_type), .alu_op_addition(alu_op_addition),
        .alu_rob_entry(alu_rob_entry)
    );

    // A dispatch is fresh only if the DUT was enabled at the edge that produced it
    always @(posedge clk_in) rdy_edge <= rdy_in && !rst_in;

    always @(negedge clk_in) begin
        if (alu_valid && rdy_edge) begin
            exp_t act;
            act = '{alu_vi, alu_vj, alu_op, alu_op_type, alu_op_addition, alu_rob_entry};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL dispatch_unexpected: got rob=%0d vi=%h vj=%h, required no dispatch",
                         alu_rob_entry, alu_vi, alu_vj);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL dispatch_payload: got rob=%0d vi=%h vj=%h op=%0d type=%b add=%0d, required rob=%0d vi=%h vj=%h op=%0d type=%b add=%0d",
                             act.rob, act.vi, act.vj, act.op, act.op_type, act.op_addition,
                             e.rob, e.vi, e.vj, e.op, e.op_type, e.op_addition);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        issue_valid   = 1'b0;
        cdb_alu_valid = 1'b0;
        cdb_lsb_valid = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [6:0] ty, input logic add,
                         input logic [3:0] rob, input logic [31:0] vi, input logic [31:0] vj,
                         input logic qiv, input logic [3:0] qi,
                         input logic qjv, input logic [3:0] qj);
        issue_valid       = 1'b1;
        issue_op          = op;
        issue_op_type     = ty;
        issue_op_addition = add;
        issue_rob_entry   = rob;
        issue_vi          = vi;
        issue_vj          = vj;
        issue_qi_valid    = qiv;
        issue_qi          = qi;
        issue_qj_valid    = qjv;
        issue_qj          = qj;
    endtask

    task automatic cdb_alu(input logic [3:0] rob, input logic [31:0] val);
        cdb_alu_valid = 1'b1;
        cdb_alu_rob   = rob;
        cdb_alu_val   = val;
    endtask

    task automatic push(input logic [31:0] vi, input logic [31:0] vj, input logic [2:0] op,
                        input logic [6:0] ty, input logic add, input logic [3:0] rob);
        exp_t e;
        e = '{vi, vj, op, ty, add, rob};
        exp_q.push_back(e);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
        issue_valid = 1'b0; issue_op = '0; issue_op_type = '0; issue_op_addition = 1'b0;
        issue_rob_entry = '0; issue_vi = '0; issue_vj = '0;
        issue_qi_valid = 1'b0; issue_qj_valid = 1'b0; issue_qi = '0; issue_qj = '0;
        cdb_alu_valid = 1'b0; cdb_alu_rob = '0; cdb_alu_val = '0;
        cdb_lsb_valid = 1'b0; cdb_lsb_rob = '0; cdb_lsb_val = '0;
        step(); step();
        rst_in = 1'b0;
        check("reset_alu_valid", 32'(alu_valid), 32'd0);
        check("reset_full", 32'(full), 32'd0);
        check("reset_alu_vi", alu_vi, 32'd0);
        check("reset_alu_rob", 32'(alu_rob_entry), 32'd0);

        // Ready add: dispatched one edge after issue, for one cycle
        issue(3'b000, OP_R, 1'b0, 4'd3, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0);
        push(32'd5, 32'd7, 3'b000, OP_R, 1'b0, 4'd3);
        step();
        check("add_issue_edge_valid", 32'(alu_valid), 32'd0);
        step();
        check("add_dispatch_valid", 32'(alu_valid), 32'd1);
        step();
        check("add_after_valid", 32'(alu_valid), 32'd0);

        // Sub waiting on tag 6, woken by ALU CDB
        issue(3'b000, OP_R, 1'b1, 4'd4, 32'd20, 32'd0, 1'b0, 4'd0, 1'b1, 4'd6);
        push(32'd20, 32'h10, 3'b000, OP_R, 1'b1, 4'd4);
        step();
        step();
        check("sub_waiting_valid", 32'(alu_valid), 32'd0);
        cdb_alu(4'd6, 32'h10);
        step();
        check("sub_wake_edge_valid", 32'(alu_valid), 32'd0);
        step();
        check("sub_dispatch_valid", 32'(alu_valid), 32'd1);
        check("sub_dispatch_add", 32'(alu_op_addition), 32'd1);
        step();

        // Same-cycle capture from the load/store CDB
        issue(3'b111, OP_I, 1'b0, 4'd5, 32'd0, 32'd3, 1'b1, 4'd2, 1'b0, 4'd0);
        cdb_lsb_valid = 1'b1; cdb_lsb_rob = 4'd2; cdb_lsb_val = 32'hDEAD;
        push(32'hDEAD, 32'd3, 3'b111, OP_I, 1'b0, 4'd5);
        step();
        step();
        check("capture_dispatch_valid", 32'(alu_valid), 32'd1);
        step();

        // Fill all eight entries on tag 9, drop a ninth, then drain
        for (int i = 0; i < 8; i++) begin
            issue(3'b000, OP_R, 1'b0, 4'(i), 32'd0, 32'(i), 1'b1, 4'd9, 1'b0, 4'd0);
            push(32'h99, 32'(i), 3'b000, OP_R, 1'b0, 4'(i));
            step();
        end
        check("fill_full", 32'(full), 32'd1);
        issue(3'b000, OP_R, 1'b0, 4'd15, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
        step();
        check("drop_full", 32'(full), 32'd1);
        check("drop_no_dispatch", 32'(alu_valid), 32'd0);
        cdb_alu(4'd9, 32'h99);
        step();
        check("wake_full", 32'(full), 32'd1);
        step();
        check("drain_first_valid", 32'(alu_valid), 32'd1);
        check("drain_first_full", 32'(full), 32'd0);
        for (int i = 1; i < 8; i++) begin
            step();
            check("drain_valid", 32'(alu_valid), 32'd1);
        end
        step();
        check("drain_done_valid", 32'(alu_valid), 32'd0);

        // Flush with five busy entries and a same-cycle issue
        for (int i = 0; i < 4; i++) begin
            issue(3'b000, OP_R, 1'b0, 4'(i), 32'd0, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0);
            step();
        end
        issue(3'b000, OP_R, 1'b0, 4'd8, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
        push(32'd1, 32'd2, 3'b000, OP_R, 1'b0, 4'd8);
        step();
        issue(3'b000, OP_R, 1'b0, 4'd4, 32'd0, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0);
        step();
        check("preflush_valid", 32'(alu_valid), 32'd1);
        flush = 1'b1;
        issue(3'b000, OP_R, 1'b0, 4'd10, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0);
        step();
        check("flush_valid", 32'(alu_valid), 32'd0);
        check("flush_full", 32'(full), 32'd0);
        cdb_alu(4'd12, 32'h12);
        step(); step(); step();
        check("postflush_valid", 32'(alu_valid), 32'd0);

        // rdy_in low freezes a live dispatch and a pending ready entry
        issue(3'b100, OP_I, 1'b0, 4'd7, 32'hA, 32'hB, 1'b0, 4'd0, 1'b0, 4'd0);
        push(32'hA, 32'hB, 3'b100, OP_I, 1'b0, 4'd7);
        step();
        issue(3'b001, OP_I, 1'b0, 4'd6, 32'hC, 32'hD, 1'b0, 4'd0, 1'b0, 4'd0);
        push(32'hC, 32'hD, 3'b001, OP_I, 1'b0, 4'd6);
        step();
        check("prefreeze_rob", 32'(alu_rob_entry), 32'd7);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("freeze_valid", 32'(alu_valid), 32'd1);
            check("freeze_rob", 32'(alu_rob_entry), 32'd7);
            check("freeze_vi", alu_vi, 32'hA);
        end
        rdy_in = 1'b1;
        step();
        check("resume_rob", 32'(alu_rob_entry), 32'd6);
        step();
        check("resume_done_valid", 32'(alu_valid), 32'd0);

        // Selection order: slot 5 issued before the refilled slot 1
        issue(3'b000, OP_R, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0); step();
        issue(3'b000, OP_R, 1'b0, 4'd1, 32'd0, 32'd1, 1'b1, 4'd11, 1'b0, 4'd0); step();
        for (int i = 2; i < 5; i++) begin
            issue(3'b000, OP_R, 1'b0, 4'(i), 32'd0, 32'(i), 1'b1, 4'd12, 1'b0, 4'd0);
            step();
        end
        issue(3'b000, OP_R, 1'b0, 4'd5, 32'd0, 32'd5, 1'b1, 4'd9, 1'b0, 4'd0); step();
        cdb_alu(4'd11, 32'h11);
        push(32'h11, 32'd1, 3'b000, OP_R, 1'b0, 4'd1);
        step();
        step();
        check("slot1_dispatch_rob", 32'(alu_rob_entry), 32'd1);
        issue(3'b000, OP_R, 1'b0, 4'd13, 32'd0, 32'd13, 1'b1, 4'd9, 1'b0, 4'd0);
        step();
        cdb_alu(4'd9, 32'h9);
`ifdef RS_OLDEST_FIRST_EN
        push(32'h9, 32'd5, 3'b000, OP_R, 1'b0, 4'd5);
        push(32'h9, 32'd13, 3'b000, OP_R, 1'b0, 4'd13);
`else
        push(32'h9, 32'd13, 3'b000, OP_R, 1'b0, 4'd13);
        push(32'h9, 32'd5, 3'b000, OP_R, 1'b0, 4'd5);
`endif
        step();
        step(); step();
        cdb_alu(4'd12, 32'h12);
        push(32'h12, 32'd0, 3'b000, OP_R, 1'b0, 4'd0);
        for (int i = 2; i < 5; i++) push(32'h12, 32'(i), 3'b000, OP_R, 1'b0, 4'(i));
        step();
        for (int i = 0; i < 6; i++) step();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("final_full", 32'(full), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
